// File: rtl/cpu_trace_buf_if.sv
// Beat stream from the trace buffer toward the debug trace port.
// master = buffer (drives beats), slave = trace port sink (drives ready).
interface cpu_trace_buf_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cpu_trace_buf.sv
// Trace packet buffer: DEPTH x 256-bit FIFO drained as eight 32-bit beats, MSB word first.
// Optional macro CPU_TRACE_FILTER_EN adds a type_mask input that filters packets by type.
//
//   state  | meaning
//   S_IDLE | nothing buffered, out_valid low
//   S_SEND | presenting beat r_beat of the packet at r_rd_ptr
module cpu_trace_buf #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    trc_en,
    input  logic                    flush,
    input  logic                    pkg_valid,
    input  logic [255:0]            pkg,
`ifdef CPU_TRACE_FILTER_EN
    input  logic [3:0]              type_mask,
`endif
    cpu_trace_buf_if.master         trc_out,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    logic [2:0]         r_beat;
    logic               r_out_valid;
    logic               r_out_last;

    logic [255:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_type_ok;
    logic               w_offer;
    logic               w_fire;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_more;
    logic [7:0][31:0]   w_words;

`ifdef CPU_TRACE_FILTER_EN
    assign w_type_ok = type_mask[pkg[255:254]];
`else
    assign w_type_ok = 1'b1;
`endif

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);

    // A packet is only "offered" if it would be kept given room; filtered or
    // disabled packets never reach the drop counter.
    assign w_offer = pkg_valid & trc_en & w_type_ok & ~flush;
    assign w_fire  = r_out_valid & trc_out.out_ready;
    assign w_pop   = w_fire & r_out_last;
    assign w_push  = w_offer & (~w_full | w_pop);
    assign w_drop  = w_offer & w_full & ~w_pop;

    // Packets left after a pop: level - 1 + push.
    assign w_more  = (r_level > LVL_W'(1)) | w_push;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty || w_push) begin
                        r_state     <= S_SEND;
                        r_out_valid <= 1'b1;
                        r_beat      <= '0;
                        r_out_last  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_fire) begin
                        if (r_out_last) begin
                            r_beat     <= '0;
                            r_out_last <= 1'b0;
                            if (!w_more) begin
                                r_state     <= S_IDLE;
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_beat     <= r_beat + 3'd1;
                            r_out_last <= (r_beat == 3'd6);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_beat      <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once level says they are valid.
    // When full, a push with a same-cycle pop overwrites the slot being retired.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pkg;
        end
    end

    assign w_words = r_mem[r_rd_ptr];

    assign trc_out.out_valid = r_out_valid;
    assign trc_out.out_last  = r_out_last;
    assign trc_out.out_data  = r_out_valid ? w_words[3'd7 - r_beat] : 32'h0;

    assign level    = r_level;
    assign full     = w_full;
    assign empty    = w_empty;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cpu_trace_buf.sv
// Directed bench for cpu_trace_buf: latency, back-pressure, overflow, full push+pop,
// flush, async reset, drop saturation, trc_en gating and (if enabled) type filtering.
module tb_cpu_trace_buf;

    localparam int DEPTH = 16;
    localparam int CNT_W = 3;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   trc_en = 1'b0;
    logic                   flush = 1'b0;
    logic                   pkg_valid = 1'b0;
    logic [255:0]           pkg = '0;
`ifdef CPU_TRACE_FILTER_EN
    logic [3:0]             type_mask = 4'hF;
`endif
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       drop_cnt;

    cpu_trace_buf_if trc_if ();

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] q [$];

    always #5 clk = ~clk;

    cpu_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .trc_en    (trc_en),
        .flush     (flush),
        .pkg_valid (pkg_valid),
        .pkg       (pkg),
`ifdef CPU_TRACE_FILTER_EN
        .type_mask (type_mask),
`endif
        .trc_out   (trc_if.master),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_pkt(input int n, input logic [1:0] t);
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[255-32*k -: 32] = {n[7:0], 8'(k), 16'hC0DE ^ 16'(n * 7)};
        end
        p[255:254] = t;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [255:0] p);
        pkg_valid = 1'b1;
        pkg       = p;
        tick();
        pkg_valid = 1'b0;
    endtask

    // Drains one packet; optional 1/0 ready toggling and a push on the last beat.
    task automatic drain(input logic [255:0] exp, input bit bp,
                         input logic [255:0] pp, input bit do_push);
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        while (beat < 8 && cyc < 64) begin
            rdy = bp ? (cyc % 2 == 0) : 1'b1;
            trc_if.out_ready = rdy;
            if (do_push && beat == 7) begin
                pkg_valid = 1'b1;
                pkg       = pp;
            end
            check("beat_valid", trc_if.out_valid, 1'b1);
            check("beat_data", trc_if.out_data, exp[255-32*beat -: 32]);
            check("beat_last", trc_if.out_last, beat == 7);
            if (bp) check("bp_level", level, 1);
            tick();
            pkg_valid = 1'b0;
            if (rdy) beat++;
            cyc++;
        end
        trc_if.out_ready = 1'b0;
        if (beat != 8) check("drain_timeout", beat, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] p1;
        logic [255:0] p2;
        logic [255:0] pn;
        logic [255:0] p;

        trc_if.out_ready = 1'b0;
        trc_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", trc_if.out_valid, 0);
        check("rst_last", trc_if.out_last, 0);
        check("rst_data", trc_if.out_data, 0);
        check("rst_drop", drop_cnt, 0);
        @(negedge clk) rstn = 1'b1;
        tick();

        // single packet, ready held high
        p1 = 256'h0123456789ABCDEF_FEDCBA9876543210_13579BDF2468ACE0_DEADBEEFCAFEF00D;
        trc_if.out_ready = 1'b1;
        push(p1);
        check("t1_level", level, 1);
        drain(p1, 1'b0, '0, 1'b0);
        check("t1_idle_valid", trc_if.out_valid, 0);
        check("t1_empty", empty, 1);

        // back-pressure
        p2 = mk_pkt(2, 2'd1);
        push(p2);
        drain(p2, 1'b1, '0, 1'b0);
        check("t2_level", level, 0);

        // overflow: DEPTH+3 pushes while stalled
        q.delete();
        for (int i = 0; i < DEPTH + 3; i++) begin
            p = mk_pkt(i + 10, 2'(i % 4));
            if (i < DEPTH) q.push_back(p);
            push(p);
        end
        check("t3_full", full, 1);
        check("t3_level", level, DEPTH);
        check("t3_drop", drop_cnt, 3);
        while (q.size() > 0) drain(q.pop_front(), 1'b0, '0, 1'b0);
        check("t3_empty", empty, 1);

        // full + push + last-beat pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            p = mk_pkt(i + 40, 2'd2);
            q.push_back(p);
            push(p);
        end
        check("t4_full_pre", full, 1);
        pn = mk_pkt(99, 2'd3);
        drain(q.pop_front(), 1'b0, pn, 1'b1);
        check("t4_level", level, DEPTH);
        check("t4_full", full, 1);
        check("t4_drop", drop_cnt, 3);
        q.push_back(pn);
        while (q.size() > 0) drain(q.pop_front(), 1'b0, '0, 1'b0);
        check("t4_empty", empty, 1);

        // flush with beat 4 in flight and a packet offered in the flush cycle
        for (int i = 0; i < 5; i++) begin
            p = mk_pkt(i + 60, 2'd0);
            if (i == 0) p1 = p;
            push(p);
        end
        trc_if.out_ready = 1'b1;
        repeat (4) tick();
        trc_if.out_ready = 1'b0;
        check("t5_beat4", trc_if.out_data, p1[127:96]);
        flush     = 1'b1;
        pkg_valid = 1'b1;
        pkg       = mk_pkt(70, 2'd3);
        tick();
        flush     = 1'b0;
        pkg_valid = 1'b0;
        check("t5_empty", empty, 1);
        check("t5_valid", trc_if.out_valid, 0);
        check("t5_drop", drop_cnt, 0);
        tick();
        check("t5_valid_after", trc_if.out_valid, 0);
        check("t5_level_after", level, 0);

        // asynchronous reset mid-packet
        push(mk_pkt(71, 2'd1));
        push(mk_pkt(72, 2'd1));
        trc_if.out_ready = 1'b1;
        repeat (3) tick();
        trc_if.out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("t5r_valid", trc_if.out_valid, 0);
        check("t5r_level", level, 0);
        check("t5r_empty", empty, 1);
        check("t5r_data", trc_if.out_data, 0);
        check("t5r_last", trc_if.out_last, 0);
        @(negedge clk) rstn = 1'b1;
        tick();
        p2 = mk_pkt(73, 2'd2);
        push(p2);
        drain(p2, 1'b0, '0, 1'b0);

        // drop counter saturation and trc_en gating
        for (int i = 0; i < DEPTH + 6; i++) push(mk_pkt(i + 80, 2'd0));
        check("t6_drop6", drop_cnt, 6);
        for (int i = 0; i < 3; i++) push(mk_pkt(i + 110, 2'd0));
        check("t6_drop_sat", drop_cnt, 7);
        trc_en = 1'b0;
        push(mk_pkt(120, 2'd0));
        check("t6_en_drop", drop_cnt, 7);
        check("t6_en_level", level, DEPTH);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush_drop", drop_cnt, 0);
        push(mk_pkt(121, 2'd3));
        tick();
        check("t6_en_empty", empty, 1);
        check("t6_en_valid", trc_if.out_valid, 0);
        trc_en = 1'b1;

`ifdef CPU_TRACE_FILTER_EN
        type_mask = 4'b1000;
        for (int t = 0; t < 4; t++) begin
            p = mk_pkt(130 + t, 2'(t));
            if (t == 3) p1 = p;
            push(p);
        end
        check("t7_level", level, 1);
        check("t7_drop", drop_cnt, 0);
        drain(p1, 1'b0, '0, 1'b0);
        check("t7_empty", empty, 1);
        type_mask = 4'hF;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
